serial_demux_1_8: RTL and testbench

- Clocked 1-to-N demultiplexing deserializer, the receive-side counterpart of mux_8_1.
- An internal select counter routes each accepted serial bit to output position 0, 1, ... N-1, rebuilding the parallel word that a mux_8_1 scanned with s = 0..7 would emit.
- Delivers completed words through a valid/ready handshake.
- Used wherever a serialized mux stream must be rebuilt into a parallel vector.

---
 rtl/serial_demux_1_8_pkg.sv | 13 +
 rtl/serial_demux_1_8_if.sv | 30 +++
 rtl/serial_demux_1_8_mod_n_counter.sv | 39 +++
 rtl/serial_demux_1_8.sv | 106 ++++++++++
 tb/tb_serial_demux_1_8.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/serial_demux_1_8_pkg.sv
// rtl/serial_demux_1_8_pkg.sv - shared constants for the serial 1-to-N demux deserializer
package serial_demux_1_8_pkg;

  // Default word geometry: eight outputs addressed by a 3-bit select
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;

  // Holding-register state: FILL means no unconsumed word, HOLD means out_data is valid
  typedef logic [0:0] state_t;
  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/serial_demux_1_8_if.sv
// rtl/serial_demux_1_8_if.sv - serial input / parallel output handshake bundle
interface serial_demux_1_8_if
  import serial_demux_1_8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
);

  logic             clr;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;

  // Demux side: consumes the serial stream, produces the parallel word
  modport slave (
    input  clr, in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel
  );

  // Environment side: drives the serial stream, takes the parallel word
  modport master (
    output clr, in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel
  );

endinterface

// File: rtl/serial_demux_1_8_mod_n_counter.sv
// rtl/serial_demux_1_8_mod_n_counter.sv - modulo-WIDTH up/down select counter with terminal-count flag
module mod_n_counter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  // Start and terminal values swap with the count direction
  localparam logic [SEL_W-1:0] TOP   = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] START = DOWN ? TOP : '0;
  localparam logic [SEL_W-1:0] LAST  = DOWN ? '0 : TOP;

  assign tc = (count == LAST);

  // Count one step per enable, wrapping at the terminal value so out-of-range values never appear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= START;
    end else if (clr) begin
      count <= START;
    end else if (en) begin
      if (tc) begin
        count <= START;
      end else if (DOWN) begin
        count <= count - 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_demux_1_8.sv
// rtl/serial_demux_1_8.sv - double-buffered 1-to-N serial demux deserializer; DEMUX_MSB_FIRST_EN selects MSB-first routing
module serial_demux_1_8
  import serial_demux_1_8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_demux_1_8_if.slave    bus
);

  // Reject illegal geometry at elaboration
  if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
    $error("serial_demux_1_8: WIDTH must be in 2..256");
  end
  if (SEL_W != $clog2(WIDTH)) begin : g_bad_sel_w
    $error("serial_demux_1_8: SEL_W must equal ceil(log2(WIDTH))");
  end

`ifdef DEMUX_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] word_done;
  logic [WIDTH-1:0] out_data_q;
  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             tc;
  logic             in_ready;
  logic             accept;
  logic             consume;
  logic             last_accept;
  logic             cnt_en;

  // Only stall when the next word is complete and the holding register is still occupied
  assign in_ready    = !((state == ST_HOLD) && !bus.out_ready && tc);
  assign accept      = bus.in_valid && in_ready;
  assign consume     = (state == ST_HOLD) && bus.out_ready;
  // clr wins over accept, so a bit arriving with clr is dropped
  assign cnt_en      = accept && !bus.clr;
  assign last_accept = cnt_en && tc;

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.sel       = sel_q;

  mod_n_counter #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W),
    .DOWN  (MSB_FIRST)
  ) u_sel_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .en    (cnt_en),
    .count (sel_q),
    .tc    (tc)
  );

  // Completed word: the shadow with the final bit merged in at its position
  always_comb begin
    word_done        = shadow;
    word_done[sel_q] = bus.in_bit;
  end

  // Collect accepted bits; empty the shadow once its word moves to the holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (bus.clr) begin
      shadow <= '0;
    end else if (accept) begin
      if (tc) begin
        shadow <= '0;
      end else begin
        shadow[sel_q] <= bus.in_bit;
      end
    end
  end

  // Holding register loads only on a last-bit accept and otherwise keeps its word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (last_accept) begin
      out_data_q <= word_done;
    end
  end

  // FILL/HOLD tracking; a new word arriving as the old one is consumed keeps HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else if (last_accept) begin
      state <= ST_HOLD;
    end else if (consume) begin
      state <= ST_FILL;
    end
  end

endmodule

// File: tb/tb_serial_demux_1_8.sv
// tb/tb_serial_demux_1_8.sv - randomized and directed bench for serial_demux_1_8 against a word-level model
module tb_serial_demux_1_8;

  localparam int W = 8;
`ifdef DEMUX_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic clk;
  logic rst_n;

  serial_demux_1_8_if #(.WIDTH(W), .SEL_W(3)) bus ();

  serial_demux_1_8 #(.WIDTH(W), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bits received into the current word, partial word, holding word and its valid
  int           k;
  logic [W-1:0] m_part;
  logic [W-1:0] m_data;
  bit           m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input int idx);
    return MSB ? (W - 1 - idx) : idx;
  endfunction

  task automatic model_reset();
    k       = 0;
    m_part  = '0;
    m_data  = '0;
    m_valid = 1'b0;
  endtask

  // One cycle: drive at the falling edge, compare, advance the model, wait for the next falling edge
  task automatic step(input bit v, input logic b, input bit r, input bit c);
    bit exp_rdy;
    bit acc;
    bit cons;
    bus.in_valid  = v;
    bus.in_bit    = v ? b : 1'bx;
    bus.out_ready = r;
    bus.clr       = c;
    #1;
    exp_rdy = !(m_valid && !r && (k == W - 1));
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("sel", 32'(bus.sel), 32'(pos_of(k)));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    acc  = v && exp_rdy;
    cons = m_valid && r;
    if (c) begin
      k      = 0;
      m_part = '0;
      if (cons) m_valid = 1'b0;
    end else if (acc && (k == W - 1)) begin
      m_data            = m_part;
      m_data[pos_of(k)] = b;
      m_valid           = 1'b1;
      k                 = 0;
      m_part            = '0;
    end else begin
      if (acc) begin
        m_part[pos_of(k)] = b;
        k++;
      end
      if (cons) m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends a word in routing order so the rebuilt word equals w in either bit order
  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = 0; i < W; i++) step(1'b1, w[pos_of(i)], r, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'(pos_of(0)));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
  endtask

  logic [W-1:0] word;
  bit   rv, rr, rc;
  logic rb;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    rst_n         = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Basic word, valid for exactly one cycle, then retained data
    send_word(8'hAA, 1'b1);
    check("basic_data", 32'(bus.out_data), 32'hAA);
    check("basic_valid", 32'(bus.out_valid), 32'h1);
    check("basic_sel_wrap", 32'(bus.sel), 32'(pos_of(0)));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_valid_drop", 32'(bus.out_valid), 32'h0);
    check("basic_data_kept", 32'(bus.out_data), 32'hAA);

    // Backpressure: second word stalls on its last bit until the first is taken
    word = 8'h0F;
    send_word(8'hAA, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b1, word[pos_of(i)], 1'b0, 1'b0);
    check("bp_stall", 32'(bus.in_ready), 32'h0);
    check("bp_sel", 32'(bus.sel), 32'(pos_of(W - 1)));
    check("bp_held", 32'(bus.out_data), 32'hAA);
    step(1'b1, word[pos_of(W - 1)], 1'b1, 1'b0);
    check("bp_new_data", 32'(bus.out_data), 32'h0F);
    check("bp_new_valid", 32'(bus.out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Gaps between bits
    word = 8'h5C;
    for (int i = 0; i < W; i++) begin
      step(1'b1, word[pos_of(i)], 1'b1, 1'b0);
      if (i < W - 1) begin
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    check("gap_data", 32'(bus.out_data), 32'h5C);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear drops the partial word and the bit presented with it
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_sel", 32'(bus.sel), 32'(pos_of(0)));
    send_word(8'hC3, 1'b1);
    check("clr_data", 32'(bus.out_data), 32'hC3);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset while a word is held and another is half built
    send_word(8'hAA, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(8'h96, 1'b1);
    check("post_rst_data", 32'(bus.out_data), 32'h96);

    // Randomized traffic with X on in_bit whenever in_valid is low
    for (int i = 0; i < 800; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 1) == 1);
      rc = ($urandom_range(0, 39) == 0);
      step(rv, rb, rr, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
